cache_line_burst_engine: RTL and testbench

//  Line fill/writeback engine directly upstream of memory_controller_burst.

---
 rtl/cache_line_burst_engine_if.sv | 51 +++++
 rtl/cache_line_burst_engine.sv | 175 +++++++++++++++++
 tb/tb_cache_line_burst_engine.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_burst_engine_if.sv
// ---------------------------------------------------------------------------
// cache_line_burst_engine_if
//   Bundles the cache-side request/buffer port and the memory-controller
//   burst port of the line burst engine.
//   Ports / signals:
//     request : req_valid, req_we, req_addr -> engine; req_ready, done, err <- engine
//     buffer  : buf_wr_en, buf_idx, buf_wdata -> engine; buf_rdata <- engine
//     memory  : mc_burst_en, mc_burst_len, mc_a, mc_d, mc_we, mc_rd <- engine;
//               mc_spo, mc_ready -> engine
//   Modports:
//     master : environment side (cache + memory controller)
//     slave  : the burst engine itself
// ---------------------------------------------------------------------------
interface cache_line_burst_engine_if #(
    parameter int LINE_WORDS = 8
) ();
    localparam int IW = $clog2(LINE_WORDS);

    logic            req_valid;
    logic            req_we;
    logic [31:0]     req_addr;
    logic            req_ready;
    logic            done;
    logic            err;
    logic            buf_wr_en;
    logic [IW-1:0]   buf_idx;
    logic [31:0]     buf_wdata;
    logic [31:0]     buf_rdata;
    logic            mc_burst_en;
    logic [7:0]      mc_burst_len;
    logic [31:0]     mc_a;
    logic [31:0]     mc_d;
    logic            mc_we;
    logic            mc_rd;
    logic [31:0]     mc_spo;
    logic            mc_ready;

    modport master (
        output req_valid, req_we, req_addr, buf_wr_en, buf_idx, buf_wdata,
               mc_spo, mc_ready,
        input  req_ready, done, err, buf_rdata, mc_burst_en, mc_burst_len,
               mc_a, mc_d, mc_we, mc_rd
    );

    modport slave (
        input  req_valid, req_we, req_addr, buf_wr_en, buf_idx, buf_wdata,
               mc_spo, mc_ready,
        output req_ready, done, err, buf_rdata, mc_burst_en, mc_burst_len,
               mc_a, mc_d, mc_we, mc_rd
    );
endinterface

// File: rtl/cache_line_burst_engine.sv
// ---------------------------------------------------------------------------
// cache_line_burst_engine
//   Holds one cache line in a local buffer and moves it to/from the memory
//   controller as a single burst: one ISSUE cycle carrying the command, then
//   one word per mc_ready strobe. Finishes with a one-cycle done pulse, or an
//   err pulse if the controller stays silent for TIMEOUT cycles.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-low reset
//     bus  : request, buffer and memory-controller signals (slave modport)
// ---------------------------------------------------------------------------
module cache_line_burst_engine #(
    parameter int LINE_WORDS = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    cache_line_burst_engine_if.slave    bus
);
    localparam int          IW         = $clog2(LINE_WORDS);
    localparam int          TW         = $clog2(TIMEOUT + 1);
    // Byte-offset bits inside one line: word index plus the 2 byte bits.
    localparam logic [31:0] ALIGN_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_XFER  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [31:0]     buf_q [LINE_WORDS];
    logic [31:0]     buf_d [LINE_WORDS];

    // Next-state, request latch, word/timeout counters and buffer updates.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.buf_wr_en) begin
                    buf_d[bus.buf_idx] = bus.buf_wdata;
                end else begin
                    buf_d = buf_q;
                end
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr & ~ALIGN_MASK;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // Any mc_ready seen here belongs to nothing and is dropped.
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                if (bus.mc_ready) begin
                    if (!we_q) begin
                        buf_d[cnt_q] = bus.mc_spo;
                    end else begin
                        buf_d = buf_q;
                    end
                    tcnt_d = '0;
                    if (cnt_q == IW'(LINE_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + IW'(1);
                        state_d = S_XFER;
                    end
                end else begin
                    // This cycle is the TIMEOUT-th silent one when the count
                    // already holds TIMEOUT-1.
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        tcnt_d  = '0;
                        cnt_d   = '0;
                        state_d = S_ERR;
                    end else begin
                        tcnt_d  = tcnt_q + TW'(1);
                        state_d = S_XFER;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            cnt_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Line buffer storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Output decode from the registered state.
    always_comb begin
        bus.req_ready    = 1'b0;
        bus.done         = 1'b0;
        bus.err          = 1'b0;
        bus.mc_burst_en  = 1'b0;
        bus.mc_burst_len = 8'h00;
        bus.mc_a         = 32'h0000_0000;
        bus.mc_d         = 32'h0000_0000;
        bus.mc_we        = 1'b0;
        bus.mc_rd        = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
            end
            S_ISSUE: begin
                bus.mc_burst_en  = 1'b1;
                bus.mc_burst_len = 8'(LINE_WORDS);
                bus.mc_a         = addr_q;
                bus.mc_we        = we_q;
                bus.mc_rd        = ~we_q;
                bus.mc_d         = buf_q[cnt_q];
            end
            S_XFER: begin
                bus.mc_burst_len = 8'(LINE_WORDS);
                bus.mc_d         = buf_q[cnt_q];
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            S_ERR: begin
                bus.err = 1'b1;
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

    assign bus.buf_rdata = buf_q[bus.buf_idx];

endmodule

// File: tb/tb_cache_line_burst_engine.sv
// ---------------------------------------------------------------------------
// tb_cache_line_burst_engine
//   Directed bench for cache_line_burst_engine (LINE_WORDS=8, TIMEOUT=4096).
//   A transaction-level model thread tracks what every output must be each
//   cycle; a negedge process compares the DUT against it. Directed tests add
//   hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_cache_line_burst_engine;
    localparam int LW = 8;
    localparam int TO = 4096;

    logic clk;
    logic rst;

    cache_line_burst_engine_if #(.LINE_WORDS(LW)) bus ();

    cache_line_burst_engine #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_bursts = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic        exp_ready, exp_done, exp_err, exp_ben, exp_we, exp_rd;
    logic [7:0]  exp_len;
    logic [31:0] exp_a;
    int          exp_didx;
    logic [31:0] mbuf [LW];
    bit          mvld [LW];

    task automatic exp_set(input logic rdy, input logic ben, input logic we, input logic rd,
                           input logic [7:0] len, input logic [31:0] a, input int didx,
                           input logic dn, input logic er);
        exp_ready = rdy; exp_ben = ben; exp_we = we; exp_rd = rd;
        exp_len = len; exp_a = a; exp_didx = didx; exp_done = dn; exp_err = er;
    endtask

    task automatic m_tick(output bit ab);
        @(posedge clk or negedge rst);
        ab = (rst == 1'b0);
    endtask

    initial begin : model
        bit          ab;
        bit          m_we;
        logic [31:0] m_a;
        int          k;
        int          idle;
        bit          ok;
        for (int i = 0; i < LW; i++) mvld[i] = 1'b0;
        forever begin
            exp_set(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, -1, 1'b0, 1'b0);
            while (1) begin
                m_tick(ab);
                if (!ab) begin
                    if (bus.buf_wr_en === 1'b1) begin
                        mbuf[bus.buf_idx] = bus.buf_wdata;
                        mvld[bus.buf_idx] = 1'b1;
                    end
                    if (bus.req_valid === 1'b1) begin
                        m_we = bus.req_we;
                        m_a  = bus.req_addr & 32'hffff_ffe0;
                        break;
                    end
                end
            end
            exp_set(1'b0, 1'b1, m_we, ~m_we, 8'd8, m_a, 0, 1'b0, 1'b0);
            m_tick(ab);
            if (ab) continue;
            k = 0; idle = 0; ok = 1'b0;
            while (1) begin
                exp_set(1'b0, 1'b0, 1'b0, 1'b0, 8'd8, 32'h0, k, 1'b0, 1'b0);
                m_tick(ab);
                if (ab) break;
                if (bus.mc_ready === 1'b1) begin
                    if (!m_we) begin
                        mbuf[k] = bus.mc_spo;
                        mvld[k] = 1'b1;
                    end
                    k++;
                    idle = 0;
                    if (k == LW) begin
                        ok = 1'b1;
                        break;
                    end
                end else begin
                    idle++;
                    if (idle == TO) break;
                end
            end
            if (ab) continue;
            exp_set(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, -1, ok, ~ok);
            m_tick(ab);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("mc_burst_en", 32'(bus.mc_burst_en), 32'(exp_ben));
        chk("mc_we", 32'(bus.mc_we), 32'(exp_we));
        chk("mc_rd", 32'(bus.mc_rd), 32'(exp_rd));
        chk("mc_burst_len", 32'(bus.mc_burst_len), 32'(exp_len));
        chk("mc_a", bus.mc_a, exp_a);
        if (exp_didx < 0) chk("mc_d", bus.mc_d, 32'h0);
        else if (mvld[exp_didx]) chk("mc_d", bus.mc_d, mbuf[exp_didx]);
        if (mvld[bus.buf_idx]) chk("buf_rdata", bus.buf_rdata, mbuf[bus.buf_idx]);
        if (bus.mc_burst_en === 1'b1) n_bursts++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] base);
        for (int i = 0; i < LW; i++) begin
            bus.buf_wr_en = 1'b1;
            bus.buf_idx   = 3'(i);
            bus.buf_wdata = base + 32'(i);
            cyc();
        end
        bus.buf_wr_en = 1'b0;
    endtask

    task automatic read_back(input string nm, input logic [31:0] base);
        for (int i = 0; i < LW; i++) begin
            bus.buf_idx = 3'(i);
            #1;
            chk(nm, bus.buf_rdata, base + 32'(i));
        end
    endtask

    // One complete transfer; base is mc_spo data for a fill, expected mc_d for a writeback.
    task automatic run_xfer(input bit we, input logic [31:0] addr, input int gap_max,
                            input logic [31:0] base, input bit hold_busy);
        int gap;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        cyc();
        bus.req_valid = hold_busy;
        if (hold_busy) begin
            bus.buf_wr_en = 1'b1;
            bus.buf_idx   = 3'd2;
            bus.buf_wdata = 32'h0000_0055;
        end
        chk("issue_burst_en", 32'(bus.mc_burst_en), 32'h1);
        chk("issue_mc_we", 32'(bus.mc_we), 32'(we));
        cyc();
        for (int i = 0; i < LW; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) cyc();
            bus.mc_ready = 1'b1;
            bus.mc_spo   = base + 32'(i);
            if (we) chk("wb_mc_d", bus.mc_d, base + 32'(i));
            cyc();
            bus.mc_ready = 1'b0;
            bus.mc_spo   = 32'h0;
        end
        bus.req_valid = 1'b0;
        bus.buf_wr_en = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'h1);
        chk("no_err", 32'(bus.err), 32'h0);
        cyc();
        chk("done_one_cycle", 32'(bus.done), 32'h0);
        chk("ready_after_done", 32'(bus.req_ready), 32'h1);
    endtask

    initial begin : stim
        int err_at;
        int bursts0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.buf_wr_en = 1'b0;
        bus.buf_idx   = 3'd0;
        bus.buf_wdata = 32'h0;
        bus.mc_spo    = 32'h0;
        bus.mc_ready  = 1'b0;
        repeat (3) cyc();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_burst_len", 32'(bus.mc_burst_len), 32'h0);
        rst = 1'b1;
        cyc();

        // Fill with literal checks on the ISSUE cycle.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h2000_abcd;
        cyc();
        bus.req_valid = 1'b0;
        chk("fill_burst_en", 32'(bus.mc_burst_en), 32'h1);
        chk("fill_mc_rd", 32'(bus.mc_rd), 32'h1);
        chk("fill_mc_a", bus.mc_a, 32'h2000_abc0);
        chk("fill_burst_len", 32'(bus.mc_burst_len), 32'd8);
        cyc();
        chk("xfer_burst_en", 32'(bus.mc_burst_en), 32'h0);
        for (int i = 0; i < LW; i++) begin
            bus.mc_ready = 1'b1;
            bus.mc_spo   = 32'h100 + 32'(i);
            cyc();
        end
        bus.mc_ready = 1'b0;
        chk("fill_done", 32'(bus.done), 32'h1);
        cyc();
        chk("fill_ready", 32'(bus.req_ready), 32'h1);
        read_back("fill_buf", 32'h0000_0100);

        // Writeback.
        preload(32'hdead_be00);
        run_xfer(1'b1, 32'h2000_abcd, 0, 32'hdead_be00, 1'b0);

        // Stalled controller: 3 readies then silence.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_1040;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.mc_ready = 1'b1;
            bus.mc_spo   = 32'h300 + 32'(i);
            cyc();
        end
        bus.mc_ready = 1'b0;
        err_at = -1;
        for (int n = 1; n <= TO + 10; n++) begin
            cyc();
            if (bus.err === 1'b1) begin
                err_at = n;
                break;
            end
        end
        chk("timeout_cycles", 32'(err_at), 32'(TO));
        cyc();
        chk("ready_after_err", 32'(bus.req_ready), 32'h1);

        // Reset after 4 of 8 readies.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_2000;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus.mc_ready = 1'b1;
            bus.mc_spo   = 32'h350 + 32'(i);
            cyc();
        end
        bus.mc_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("arst_burst_len", 32'(bus.mc_burst_len), 32'h0);
        chk("arst_mc_d", bus.mc_d, 32'h0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("arst_done_err", {30'h0, bus.done, bus.err}, 32'h0);
        cyc();
        rst = 1'b1;
        cyc();
        run_xfer(1'b0, 32'h0000_3000, 0, 32'h0000_0400, 1'b0);
        read_back("refill_buf", 32'h0000_0400);

        // Busy rules: req_valid and buf_wr_en held through a writeback.
        preload(32'hdead_be00);
        bursts0 = n_bursts;
        run_xfer(1'b1, 32'h4000_0010, 0, 32'hdead_be00, 1'b1);
        chk("busy_one_burst", 32'(n_bursts - bursts0), 32'h1);
        bus.buf_idx = 3'd2;
        #1;
        chk("busy_buf2", bus.buf_rdata, 32'hdead_be02);

        // Irregular ready spacing, fill then writeback back-to-back.
        run_xfer(1'b0, 32'h5000_0020, 20, 32'h6000_0000, 1'b0);
        read_back("gap_buf", 32'h6000_0000);
        run_xfer(1'b1, 32'h5000_0020, 20, 32'h6000_0000, 1'b0);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
